// File: rtl/stage_wb_pkg.sv
// Shared pipeline constants: control opcodes, write-back FSM encoding and the $zero register index.
package stage_wb_pkg;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;

  localparam logic [1:0] StRun   = 2'd0;
  localparam logic [1:0] StDrain = 2'd1;
  localparam logic [1:0] StHalt  = 2'd2;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_pipe_reg.sv
// MEM/WB pipeline register: loads on handshake, drops valid on any edge without one.
module wb_pipe_reg #(
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic                 clear_i,
  input  logic                 reg_write_i,
  input  logic [4:0]           write_reg_i,
  input  logic [DataWidth-1:0] data_i,
  output logic                 valid_o,
  output logic                 reg_write_o,
  output logic [4:0]           write_reg_o,
  output logic [DataWidth-1:0] data_o
);

  logic                 valid_d, valid_q;
  logic                 reg_write_d, reg_write_q;
  logic [4:0]           write_reg_d, write_reg_q;
  logic [DataWidth-1:0] data_d, data_q;

  always_comb begin
    valid_d     = valid_q;
    reg_write_d = reg_write_q;
    write_reg_d = write_reg_q;
    data_d      = data_q;
    if (load_i) begin
      valid_d     = 1'b1;
      reg_write_d = reg_write_i;
      write_reg_d = write_reg_i;
      data_d      = data_i;
    end else if (clear_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      write_reg_q <= '0;
      data_q      <= '0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      write_reg_q <= write_reg_d;
      data_q      <= data_d;
    end
  end

  assign valid_o     = valid_q;
  assign reg_write_o = reg_write_q;
  assign write_reg_o = write_reg_q;
  assign data_o      = data_q;

endmodule

// File: rtl/stage_wb.sv
// Write-back stage: MEM/WB capture, register-file write gating, retirement counter and halt FSM.
module stage_wb
  import stage_wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned RETIRE_LIMIT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_reg_write,
  input  logic                  in_mem_to_reg,
  input  logic [DATA_WIDTH-1:0] in_alu_result,
  input  logic [DATA_WIDTH-1:0] in_mem_data,
  input  logic [4:0]            in_write_reg,
  output logic                  wb_we,
  output logic [4:0]            wb_addr,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic [31:0]           retired_count,
  output logic                  halted
);

  localparam logic [31:0] Limit = 32'(RETIRE_LIMIT);

  logic [1:0]            state_d, state_q;
  logic [31:0]           retired_count_d, retired_count_q;
  logic                  handshake;
  logic                  last_accept;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  valid_q;
  logic                  reg_write_q;
  logic [4:0]            write_reg_q;
  logic [DATA_WIDTH-1:0] data_q;

  assign in_ready  = (state_q == StRun);
  assign halted    = (state_q == StHalt);
  assign handshake = in_valid & in_ready;
  assign sel_data  = in_mem_to_reg ? in_mem_data : in_alu_result;

  wb_pipe_reg #(
    .DataWidth (DATA_WIDTH)
  ) u_wb_pipe_reg (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .load_i      (handshake),
    .clear_i     (~handshake),
    .reg_write_i (in_reg_write),
    .write_reg_i (in_write_reg),
    .data_i      (sel_data),
    .valid_o     (valid_q),
    .reg_write_o (reg_write_q),
    .write_reg_o (write_reg_q),
    .data_o      (data_q)
  );

  // At most one entry is in flight, so accepted = retired + in-flight.
  assign last_accept = (retired_count_q + {31'b0, valid_q} + 32'd1) == Limit;

  always_comb begin
    retired_count_d = retired_count_q;
    if (valid_q && (retired_count_q != Limit)) begin
      retired_count_d = retired_count_q + 32'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StRun:   if (handshake && last_accept) state_d = StDrain;
      StDrain: state_d = StHalt;
      StHalt:  state_d = StHalt;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StRun;
      retired_count_q <= '0;
    end else begin
      state_q         <= state_d;
      retired_count_q <= retired_count_d;
    end
  end

  assign wb_we         = valid_q & reg_write_q & (write_reg_q != REG_ZERO);
  assign wb_addr       = write_reg_q;
  assign wb_data       = data_q;
  assign retired_count = retired_count_q;

endmodule

// File: tb/tb_stage_wb.sv
// Directed bench for stage_wb: single retirements, $zero/store gating, reset flush and halt limit.
module tb_stage_wb;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_reg_write;
  logic        in_mem_to_reg;
  logic [31:0] in_alu_result;
  logic [31:0] in_mem_data;
  logic [4:0]  in_write_reg;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] retired_count;
  logic        halted;

  int unsigned n_vec;
  int unsigned n_err;
  logic        saw_r12_write;

  stage_wb #(
    .DATA_WIDTH   (32),
    .RETIRE_LIMIT (15)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_reg_write  (in_reg_write),
    .in_mem_to_reg (in_mem_to_reg),
    .in_alu_result (in_alu_result),
    .in_mem_data   (in_mem_data),
    .in_write_reg  (in_write_reg),
    .wb_we         (wb_we),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .retired_count (retired_count),
    .halted        (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wb_we && wb_addr == 5'd12) saw_r12_write = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [4:0] wr);
    in_valid      = v;
    in_reg_write  = rw;
    in_mem_to_reg = m2r;
    in_alu_result = alu;
    in_mem_data   = mem;
    in_write_reg  = wr;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    n_vec         = 0;
    n_err         = 0;
    saw_r12_write = 1'b0;
    idle();
    rst_n = 1'b0;
    #2;
    check("rst_ready_async", {31'b0, in_ready}, 32'd1);
    step();
    step();
    check("rst_we", {31'b0, wb_we}, 32'd0);
    check("rst_addr", {27'b0, wb_addr}, 32'd0);
    check("rst_data", wb_data, 32'd0);
    check("rst_count", retired_count, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    rst_n = 1'b1;
    step();

    // R-type to r9
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0005, 32'h0, 5'd9);
    step();
    idle();
    check("rtype_we", {31'b0, wb_we}, 32'd1);
    check("rtype_addr", {27'b0, wb_addr}, 32'd9);
    check("rtype_data", wb_data, 32'd5);
    step();
    check("rtype_count", retired_count, 32'd1);
    check("rtype_no_rewrite", {31'b0, wb_we}, 32'd0);

    // Load to r11 selects memory data
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 5'd11);
    step();
    idle();
    check("load_we", {31'b0, wb_we}, 32'd1);
    check("load_addr", {27'b0, wb_addr}, 32'd11);
    check("load_data", wb_data, 32'hDEAD_BEEF);
    step();
    check("load_count", retired_count, 32'd2);

    // Write to $zero is suppressed but retires
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0077, 32'h0, 5'd0);
    step();
    idle();
    check("zero_we", {31'b0, wb_we}, 32'd0);
    step();
    check("zero_count", retired_count, 32'd3);

    // Store: no register write, still retires
    drive(1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 5'd7);
    step();
    idle();
    check("store_we", {31'b0, wb_we}, 32'd0);
    step();
    check("store_count", retired_count, 32'd4);

    // Reset between capture and commit of r12
    saw_r12_write = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h0000_1234, 32'h0, 5'd12);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    idle();
    #1;
    check("flush_we", {31'b0, wb_we}, 32'd0);
    check("flush_addr", {27'b0, wb_addr}, 32'd0);
    check("flush_data", wb_data, 32'd0);
    check("flush_count", retired_count, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("flush_no_r12", {31'b0, saw_r12_write}, 32'd0);
    check("flush_count_after", retired_count, 32'd0);
    check("flush_ready", {31'b0, in_ready}, 32'd1);

    // 15 back-to-back instructions reach the retirement limit
    for (int i = 1; i <= 15; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'(i * 3 + 7), 32'h0, 5'(i));
      step();
      check($sformatf("b2b_data_%0d", i), wb_data, 32'(i * 3 + 7));
      check($sformatf("b2b_count_%0d", i), retired_count, 32'(i - 1));
      check($sformatf("b2b_ready_%0d", i), {31'b0, in_ready}, (i < 15) ? 32'd1 : 32'd0);
    end
    check("drain_halted", {31'b0, halted}, 32'd0);
    check("drain_we", {31'b0, wb_we}, 32'd1);
    // 16th instruction stays presented and must be ignored
    drive(1'b1, 1'b1, 1'b0, 32'hFFFF_0000, 32'h0, 5'd20);
    step();
    check("halt_halted", {31'b0, halted}, 32'd1);
    check("halt_count", retired_count, 32'd15);
    check("halt_ready", {31'b0, in_ready}, 32'd0);
    check("halt_we", {31'b0, wb_we}, 32'd0);
    step();
    step();
    check("halt_count_hold", retired_count, 32'd15);
    check("halt_we_hold", {31'b0, wb_we}, 32'd0);
    check("halt_addr_hold", {27'b0, wb_addr}, 32'd15);
    check("halt_sticky", {31'b0, halted}, 32'd1);

    // Reset leaves HALT
    idle();
    apply_reset();
    check("rerun_halted", {31'b0, halted}, 32'd0);
    check("rerun_ready", {31'b0, in_ready}, 32'd1);
    check("rerun_count", retired_count, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
